// File: rtl/knn_vote_if.sv
// knn_vote_if: request/result bus for the k-NN majority-vote block.
// The master drives start and nb_list. The slave returns busy, done and the vote result.
interface knn_vote_if #(
    parameter int unsigned K         = 4,
    parameter int unsigned LABEL_W   = 8,
    parameter int unsigned DATA_INFO = 40
) ();
    localparam int unsigned VOTE_W = $clog2(K + 1);

    logic                     start;
    logic [K*DATA_INFO-1:0]   nb_list;
    logic                     busy;
    logic                     done;
    logic [LABEL_W-1:0]       label_out;
    logic [VOTE_W-1:0]        votes_out;
    logic                     empty;

    modport master (
        output start, nb_list,
        input  busy, done, label_out, votes_out, empty
    );

    modport slave (
        input  start, nb_list,
        output busy, done, label_out, votes_out, empty
    );
endinterface

// File: rtl/knn_vote.sv
// knn_vote: majority vote over a K-entry neighbour list.
// On start, the list is snapshotted. The block then scans one entry per cycle for K cycles.
// It reports the label with the most votes. Ties in vote count go to the smaller distance,
// and after that to the lower index. An entry whose distance is all-ones is an unused slot.
// Optional macro KNN_VOTE_STATS_EN adds cls_cnt, a saturating 16-bit count of done pulses.
module knn_vote #(
    parameter int unsigned K         = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LABEL_W   = 8,
    parameter int unsigned DATA_INFO = LABEL_W + DATA_W
) (
    input  logic        clk,
    input  logic        rst,
    knn_vote_if.slave   bus
`ifdef KNN_VOTE_STATS_EN
    ,
    output logic [15:0] cls_cnt
`endif
);
    localparam int unsigned CW = $clog2(K + 1);
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                 state_q, next_state;
    logic [K*DATA_INFO-1:0] snap_q, snap_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          best_cnt_q, best_cnt_d;
    logic [DATA_W-1:0]      best_dist_q, best_dist_d;
    logic [LABEL_W-1:0]     best_label_q, best_label_d;
    logic                   busy_d, done_d, empty_d;
    logic [LABEL_W-1:0]     label_d;
    logic [CW-1:0]          votes_d;

    logic [DATA_INFO-1:0]   cur_entry, ent_j;
    logic [LABEL_W-1:0]     cur_label;
    logic [DATA_W-1:0]      cur_dist;
    logic                   cur_valid;
    logic [CW-1:0]          cur_cnt;
    logic                   cur_better;

    // Vote count for the entry under the scan index, compared against the current best
    always_comb begin
        cur_entry  = snap_q[int'(idx_q)*DATA_INFO +: DATA_INFO];
        cur_label  = cur_entry[DATA_INFO-1 -: LABEL_W];
        cur_dist   = cur_entry[DATA_W-1:0];
        cur_valid  = (cur_dist != {DATA_W{1'b1}});
        cur_cnt    = '0;
        ent_j      = '0;
        for (int j = 0; j < int'(K); j++) begin
            ent_j = snap_q[j*DATA_INFO +: DATA_INFO];
            if ((ent_j[DATA_W-1:0] != {DATA_W{1'b1}}) &&
                (ent_j[DATA_INFO-1 -: LABEL_W] == cur_label))
                cur_cnt = cur_cnt + CW'(1);
        end
        cur_better = cur_valid &&
                     ((cur_cnt > best_cnt_q) ||
                      ((cur_cnt == best_cnt_q) && (cur_dist < best_dist_q)));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= next_state;
    end

    // Next-state logic; start is honoured only in IDLE
    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:    if (bus.start) next_state = SCAN;
            SCAN:    if (idx_q == IW'(K - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        snap_d       = snap_q;
        idx_d        = idx_q;
        best_cnt_d   = best_cnt_q;
        best_dist_d  = best_dist_q;
        best_label_d = best_label_q;
        done_d       = 1'b0;
        label_d      = bus.label_out;
        votes_d      = bus.votes_out;
        empty_d      = bus.empty;
        busy_d       = (next_state != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    snap_d       = bus.nb_list;
                    idx_d        = '0;
                    best_cnt_d   = '0;
                    best_dist_d  = {DATA_W{1'b1}};
                    best_label_d = '0;
                end
            end
            SCAN: begin
                if (cur_better) begin
                    best_cnt_d   = cur_cnt;
                    best_dist_d  = cur_dist;
                    best_label_d = cur_label;
                end
                idx_d = (idx_q == IW'(K - 1)) ? '0 : idx_q + IW'(1);
            end
            DONE: begin
                done_d  = 1'b1;
                label_d = best_label_q;
                votes_d = best_cnt_q;
                empty_d = (best_cnt_q == '0);
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q        <= '0;
            idx_q         <= '0;
            best_cnt_q    <= '0;
            best_dist_q   <= '0;
            best_label_q  <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.label_out <= '0;
            bus.votes_out <= '0;
            bus.empty     <= 1'b0;
        end else begin
            snap_q        <= snap_d;
            idx_q         <= idx_d;
            best_cnt_q    <= best_cnt_d;
            best_dist_q   <= best_dist_d;
            best_label_q  <= best_label_d;
            bus.busy      <= busy_d;
            bus.done      <= done_d;
            bus.label_out <= label_d;
            bus.votes_out <= votes_d;
            bus.empty     <= empty_d;
        end
    end

`ifdef KNN_VOTE_STATS_EN
    // Saturating count of done pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            cls_cnt <= '0;
        else if (done_d && cls_cnt != 16'hFFFF) cls_cnt <= cls_cnt + 16'd1;
    end
`endif
endmodule
